irqctrl_vectored: RTL and testbench
===================================

# irqctrl_vectored

Parametrised, vectored, priority interrupt controller for the f8 I/O system; next generation of the 2-input interrupt controller. Accepts up to 16 interrupt sources with per-source enable and edge/level mode. Resolves fixed priority with an in-service mask for nesting, and presents a vector to the core through an acknowledge/end-of-interrupt handshake. Sits on the I/O data bus beside the timer, watchdog and GPIO blocks.

## Interface
- NUM_INPUTS, 8, number of interrupt sources (1..16); index 0 is highest priority.
- ADDRBASE, 16'h0010, even base address of the 8-byte register window.
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in  in  NUM_INPUTS  raw interrupt request lines.
- dread_addr  in  16  read address.
- dread_data  out  16  registered read data.
- dwrite_addr  in  16  write address.
- dwrite_data  in  16  write data.
- dwrite_en  in  2  byte write enables: [0] low byte, [1] high byte.
- int_out  out  1  registered interrupt request to core.
- ack  in  1  one-cycle pulse, core accepting the interrupt.
- ack_vector  out  4  index of highest-priority pending, enabled, unmasked source.

## Operation
- Registers are 16 bits wide. Bits at NUM_INPUTS and above read 0 and ignore writes. Writes use only even addresses. A write with dwrite_addr[0]=1 is ignored.
  - ENABLE, at ADDRBASE: RW, 1 = source enabled.
  - PENDING, at +2: read returns pending. Writing 1 clears a bit, but only for edge-mode bits.
  - MODE, at +4: RW, 1 = rising-edge, 0 = level.
  - VECTOR, at +6: read returns {8'b0, valid, 3'b0, ack_vector}. Any write with dwrite_en[0]=1 is an EOI.
- Level mode: pending[i] follows the sampled in[i] every cycle.
- Edge mode: pending[i] is set when sampled in[i]=1 and in_prev[i]=0. It stays set until W1C or ack.
- active = pending & ENABLE.
- ISR is the in-service register.
- cand = lowest index set in active.
- Interrupt qualifies when cand exists and is lower (higher priority) than the lowest set ISR bit, or ISR=0.
- valid = qualifies. ack_vector = cand when valid, else 0.
- ack with valid=1:
  - ISR[ack_vector] is set.
  - If that source is in edge mode, its pending bit is cleared.
- ack with valid=0: ignored.
- EOI clears the lowest set ISR bit. EOI with ISR=0: no effect.
- Simultaneous events:
  - Edge set and W1C/ack clear of the same bit in one cycle: set wins.
  - EOI and ack in one cycle: EOI clears the old lowest ISR bit, then ack sets its bit. If both target the same bit, set wins.
  - W1C on level-mode bits: ignored.
- Changing MODE from level to edge leaves pending as it is. Edge detection uses in_prev, which is always updated.
- Reset mid-operation clears all state immediately (asynchronous).

## Timing
- Reset values: ENABLE, PENDING, MODE, ISR, in_prev = 0. int_out=0, ack_vector=0, dread_data=0.
- Input to pending: an in edge sampled at clock edge k sets pending at k.
- int_out is registered from valid, so it is asserted after edge k+1. Deasserts one cycle after valid falls.
- ack_vector is combinational from registered state.
- Read latency is 1 cycle: dread_data at edge k+1 reflects dread_addr and state at edge k. Unmapped or odd addresses read 0.
- Register writes take effect at the same edge. Reads of the written address in that cycle return the old value.
- ack and EOI are sampled on clk. ISR updates at that edge. int_out reflects the result one edge later.

## Configuration
- IRQCTRL_SYNC_EN:
  - Defined: each in bit passes through a two-flop synchroniser (reset 0) before edge/level logic. This adds 2 cycles input-to-pending latency.
  - Undefined: in is sampled directly. Sources must be synchronous to clk.

## Test plan
- Reset with in=8'hFF, then release → ENABLE=PENDING=MODE=0, int_out=0, read of +2 returns 16'h00FF after 1 cycle (level mode follows inputs).
- ENABLE=8'h0C, MODE=8'h0C, pulse in[3] then in[2] one cycle apart → PENDING=8'h0C, ack_vector=2, int_out=1 two cycles after the in[3] pulse (no SYNC).
- In the above state, ack → ISR=8'h04, PENDING=8'h08, int_out drops (3 is lower priority); EOI → int_out reasserts with ack_vector=3.
- Nesting: ISR bit 5 set, level in[1]=1 enabled → int_out=1 and ack_vector=1; ack → ISR=8'h22; EOI → ISR=8'h20.
- Edge pulse on in[0] in the same cycle as W1C of bit 0 → PENDING[0]=1 (set wins); W1C on a level-mode bit → unchanged.
- Write with dwrite_addr=ADDRBASE+1 → no register change. With IRQCTRL_SYNC_EN defined, in→pending latency is measured as 3 edges.

Source files
------------

// File: rtl/irqctrl_vectored_if.sv
// ---------------------------------------------------------------------------
// irqctrl_vectored_if
// Bus and interrupt handshake bundle between the f8 core (master) and the
// vectored interrupt controller (slave).
//   dread_addr  : read address (master -> slave)
//   dread_data  : registered read data (slave -> master)
//   dwrite_addr : write address (master -> slave)
//   dwrite_data : write data (master -> slave)
//   dwrite_en   : byte write enables, [0] low byte, [1] high byte
//   int_out     : registered interrupt request to the core
//   ack         : one-cycle pulse, core accepts the presented vector
//   ack_vector  : index of the highest-priority qualifying source
// ---------------------------------------------------------------------------
interface irqctrl_vectored_if;
    logic [15:0] dread_addr;
    logic [15:0] dread_data;
    logic [15:0] dwrite_addr;
    logic [15:0] dwrite_data;
    logic [1:0]  dwrite_en;
    logic        int_out;
    logic        ack;
    logic [3:0]  ack_vector;

    modport master (
        output dread_addr, dwrite_addr, dwrite_data, dwrite_en, ack,
        input  dread_data, int_out, ack_vector
    );

    modport slave (
        input  dread_addr, dwrite_addr, dwrite_data, dwrite_en, ack,
        output dread_data, int_out, ack_vector
    );
endinterface

// File: rtl/irqctrl_vectored.sv
// ---------------------------------------------------------------------------
// irqctrl_vectored
// Vectored fixed-priority interrupt controller with per-source enable,
// edge/level mode, and an in-service register (ISR) for nesting.
// Index 0 is the highest priority.
//
// Ports:
//   clk   : system clock, all state on rising edge
//   reset : asynchronous active-low reset
//   in    : raw interrupt request lines (NUM_INPUTS wide)
//   bus   : irqctrl_vectored_if.slave (register bus + ack/vector handshake)
//
// Register window (16-bit, even addresses only):
//   ADDRBASE+0 ENABLE  RW
//   ADDRBASE+2 PENDING read / write-1-to-clear (edge-mode bits only)
//   ADDRBASE+4 MODE    RW, 1 = rising edge, 0 = level
//   ADDRBASE+6 VECTOR  read {8'b0, valid, 3'b0, ack_vector}; write low byte = EOI
//
// Build option: define IRQCTRL_SYNC_EN to put a two-flop synchroniser on
// every input line (adds two cycles of input-to-pending latency).
// ---------------------------------------------------------------------------
module irqctrl_vectored #(
    parameter int          NUM_INPUTS = 8,
    parameter logic [15:0] ADDRBASE   = 16'h0010
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] in,
    irqctrl_vectored_if.slave     bus
);

    // Mask of register bits backed by an interrupt source.
    localparam logic [15:0] IMPL_MASK   = 16'((17'd1 << NUM_INPUTS) - 17'd1);
    localparam logic [15:0] ADDR_ENABLE = ADDRBASE;
    localparam logic [15:0] ADDR_PEND   = ADDRBASE + 16'd2;
    localparam logic [15:0] ADDR_MODE   = ADDRBASE + 16'd4;
    localparam logic [15:0] ADDR_VECTOR = ADDRBASE + 16'd6;

    // Index of the lowest set bit (0 when none is set).
    function automatic logic [3:0] lowest_idx(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // One-hot of the lowest set bit (0 when none is set).
    function automatic logic [15:0] lowest_onehot(input logic [15:0] v);
        return v & (~v + 16'd1);
    endfunction

    logic [15:0] enable_r;
    logic [15:0] pending_r;
    logic [15:0] mode_r;
    logic [15:0] isr_r;
    logic [15:0] in_prev_r;
    logic        int_out_r;
    logic [15:0] dread_data_r;

    logic [15:0] samp_s;
    logic [15:0] active_s;
    logic [15:0] isr_low_s;
    logic [3:0]  cand_s;
    logic        valid_s;
    logic [3:0]  ack_vector_s;
    logic [15:0] ack_onehot_s;
    logic        ack_take_s;
    logic [15:0] byte_mask_s;
    logic        wr_even_s;
    logic        wr_enable_s;
    logic        wr_pend_s;
    logic        wr_mode_s;
    logic        eoi_s;
    logic [15:0] w1c_s;
    logic [15:0] ack_clr_s;
    logic [15:0] rise_s;
    logic [15:0] enable_nxt_s;
    logic [15:0] mode_nxt_s;
    logic [15:0] pending_nxt_s;
    logic [15:0] isr_nxt_s;
    logic [15:0] rdata_s;

`ifdef IRQCTRL_SYNC_EN
    logic [NUM_INPUTS-1:0] sync1_r;
    logic [NUM_INPUTS-1:0] sync2_r;

    // Two-flop synchroniser for asynchronous request lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= in;
            sync2_r <= sync1_r;
        end
    end

    assign samp_s = 16'(sync2_r);
`else
    assign samp_s = 16'(in);
`endif

    // Priority resolution against the in-service mask.
    always_comb begin
        active_s     = pending_r & enable_r;
        cand_s       = lowest_idx(active_s);
        isr_low_s    = lowest_onehot(isr_r);
        // isr_low-1 masks every bit strictly above the lowest ISR bit; when
        // ISR is empty it wraps to all ones so any active source qualifies.
        valid_s      = |(active_s & (isr_low_s - 16'd1));
        ack_vector_s = valid_s ? cand_s : 4'd0;
        ack_onehot_s = 16'd1 << ack_vector_s;
        ack_take_s   = bus.ack & valid_s;
    end

    // Write decode and next-state computation for all architectural state.
    always_comb begin
        byte_mask_s  = {{8{bus.dwrite_en[1]}}, {8{bus.dwrite_en[0]}}};
        wr_even_s    = ~bus.dwrite_addr[0];
        wr_enable_s  = wr_even_s && (bus.dwrite_addr == ADDR_ENABLE);
        wr_pend_s    = wr_even_s && (bus.dwrite_addr == ADDR_PEND);
        wr_mode_s    = wr_even_s && (bus.dwrite_addr == ADDR_MODE);
        eoi_s        = wr_even_s && (bus.dwrite_addr == ADDR_VECTOR) && bus.dwrite_en[0];

        if (wr_enable_s) begin
            enable_nxt_s = ((enable_r & ~byte_mask_s) | (bus.dwrite_data & byte_mask_s)) & IMPL_MASK;
        end else begin
            enable_nxt_s = enable_r;
        end

        if (wr_mode_s) begin
            mode_nxt_s = ((mode_r & ~byte_mask_s) | (bus.dwrite_data & byte_mask_s)) & IMPL_MASK;
        end else begin
            mode_nxt_s = mode_r;
        end

        // Clears only ever touch edge-mode bits; level bits track the input.
        if (wr_pend_s) begin
            w1c_s = bus.dwrite_data & byte_mask_s & mode_r;
        end else begin
            w1c_s = 16'd0;
        end

        if (ack_take_s) begin
            ack_clr_s = ack_onehot_s & mode_r;
        end else begin
            ack_clr_s = 16'd0;
        end

        // A fresh rising edge overrides any clear in the same cycle.
        rise_s        = samp_s & ~in_prev_r;
        pending_nxt_s = ((mode_r & ((pending_r & ~(w1c_s | ack_clr_s)) | rise_s))
                        | (~mode_r & samp_s)) & IMPL_MASK;

        // EOI retires the old lowest ISR bit first; an ack in the same cycle
        // then sets its own bit on top.
        if (eoi_s) begin
            isr_nxt_s = isr_r & ~isr_low_s;
        end else begin
            isr_nxt_s = isr_r;
        end
        if (ack_take_s) begin
            isr_nxt_s = isr_nxt_s | ack_onehot_s;
        end else begin
            isr_nxt_s = isr_nxt_s;
        end
    end

    // Read mux; odd and unmapped addresses fall through to zero.
    always_comb begin
        rdata_s = 16'd0;
        case (bus.dread_addr)
            ADDR_ENABLE: rdata_s = enable_r;
            ADDR_PEND:   rdata_s = pending_r;
            ADDR_MODE:   rdata_s = mode_r;
            ADDR_VECTOR: rdata_s = {8'd0, valid_s, 3'd0, ack_vector_s};
            default:     rdata_s = 16'd0;
        endcase
    end

    // Architectural state, registered read data and interrupt request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable_r     <= 16'd0;
            pending_r    <= 16'd0;
            mode_r       <= 16'd0;
            isr_r        <= 16'd0;
            in_prev_r    <= 16'd0;
            int_out_r    <= 1'b0;
            dread_data_r <= 16'd0;
        end else begin
            enable_r     <= enable_nxt_s;
            pending_r    <= pending_nxt_s;
            mode_r       <= mode_nxt_s;
            isr_r        <= isr_nxt_s & IMPL_MASK;
            in_prev_r    <= samp_s & IMPL_MASK;
            int_out_r    <= valid_s;
            dread_data_r <= rdata_s;
        end
    end

    assign bus.dread_data = dread_data_r;
    assign bus.int_out    = int_out_r;
    assign bus.ack_vector = ack_vector_s;

endmodule

// File: tb/tb_irqctrl_vectored.sv
// ---------------------------------------------------------------------------
// tb_irqctrl_vectored
// Directed self-checking bench for irqctrl_vectored (NUM_INPUTS=8,
// ADDRBASE=16'h0010). Inputs are driven and outputs sampled 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_irqctrl_vectored;

    logic       clk;
    logic       reset;
    logic [7:0] irq_in;
    int         runs;
    int         fails;

    irqctrl_vectored_if bus ();

    irqctrl_vectored #(
        .NUM_INPUTS (8),
        .ADDRBASE   (16'h0010)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .in    (irq_in),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] e);
        bus.dwrite_addr = a;
        bus.dwrite_data = d;
        bus.dwrite_en   = e;
        step();
        bus.dwrite_en   = 2'b00;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        bus.dread_addr = a;
        step();
        d = bus.dread_data;
    endtask

    task automatic apply_reset();
        reset  = 1'b0;
        irq_in = 8'h00;
        bus.ack = 1'b0;
        bus.dwrite_en = 2'b00;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        logic [15:0] d;
        reset  = 1'b0;
        irq_in = 8'hFF;
        step();
        step();
        runs++; if (bus.int_out !== 1'b0) begin fails++; $display("FAIL rst_int_out: got %b want 0", bus.int_out); end
        runs++; if (bus.ack_vector !== 4'd0) begin fails++; $display("FAIL rst_vector: got %0d want 0", bus.ack_vector); end
        runs++; if (bus.dread_data !== 16'h0000) begin fails++; $display("FAIL rst_rdata: got %h want 0000", bus.dread_data); end
        reset = 1'b1;
        step();
        rd(16'h0012, d);
        runs++; if (d !== 16'h00FF) begin fails++; $display("FAIL rst_pending: got %h want 00ff", d); end
        rd(16'h0010, d);
        runs++; if (d !== 16'h0000) begin fails++; $display("FAIL rst_enable: got %h want 0000", d); end
        rd(16'h0014, d);
        runs++; if (d !== 16'h0000) begin fails++; $display("FAIL rst_mode: got %h want 0000", d); end
        runs++; if (bus.int_out !== 1'b0) begin fails++; $display("FAIL rst_int_after: got %b want 0", bus.int_out); end
        irq_in = 8'h00;
        step();
    endtask

    task automatic test_edge_priority();
        logic [15:0] d;
        apply_reset();
        wr(16'h0010, 16'h000C, 2'b11);
        wr(16'h0014, 16'h000C, 2'b11);
        irq_in = 8'h08;
        step();
        runs++; if (bus.int_out !== 1'b0) begin fails++; $display("FAIL edge_int_latency: got %b want 0", bus.int_out); end
        irq_in = 8'h04;
        step();
        runs++; if (bus.int_out !== 1'b1) begin fails++; $display("FAIL edge_int_out: got %b want 1", bus.int_out); end
        irq_in = 8'h00;
        step();
        runs++; if (bus.ack_vector !== 4'd2) begin fails++; $display("FAIL edge_vector: got %0d want 2", bus.ack_vector); end
        rd(16'h0012, d);
        runs++; if (d !== 16'h000C) begin fails++; $display("FAIL edge_pending: got %h want 000c", d); end
        rd(16'h0016, d);
        runs++; if (d !== 16'h0082) begin fails++; $display("FAIL edge_vector_reg: got %h want 0082", d); end
    endtask

    task automatic test_ack_eoi();
        logic [15:0] d;
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        runs++; if (dut.isr_r !== 16'h0004) begin fails++; $display("FAIL ack_isr: got %h want 0004", dut.isr_r); end
        step();
        runs++; if (bus.int_out !== 1'b0) begin fails++; $display("FAIL ack_int_drop: got %b want 0", bus.int_out); end
        runs++; if (bus.ack_vector !== 4'd0) begin fails++; $display("FAIL ack_vector_zero: got %0d want 0", bus.ack_vector); end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        runs++; if (dut.isr_r !== 16'h0004) begin fails++; $display("FAIL ack_invalid_ignored: got %h want 0004", dut.isr_r); end
        rd(16'h0012, d);
        runs++; if (d !== 16'h0008) begin fails++; $display("FAIL ack_pending: got %h want 0008", d); end
        wr(16'h0016, 16'h0000, 2'b01);
        runs++; if (dut.isr_r !== 16'h0000) begin fails++; $display("FAIL eoi_isr: got %h want 0000", dut.isr_r); end
        step();
        runs++; if (bus.int_out !== 1'b1) begin fails++; $display("FAIL eoi_int_reassert: got %b want 1", bus.int_out); end
        runs++; if (bus.ack_vector !== 4'd3) begin fails++; $display("FAIL eoi_vector: got %0d want 3", bus.ack_vector); end
        wr(16'h0016, 16'h0000, 2'b01);
        runs++; if (dut.isr_r !== 16'h0000) begin fails++; $display("FAIL eoi_empty: got %h want 0000", dut.isr_r); end
    endtask

    task automatic test_nesting();
        apply_reset();
        wr(16'h0010, 16'h0020, 2'b11);
        irq_in = 8'h20;
        step();
        step();
        runs++; if (bus.ack_vector !== 4'd5) begin fails++; $display("FAIL nest_vector5: got %0d want 5", bus.ack_vector); end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        runs++; if (dut.isr_r !== 16'h0020) begin fails++; $display("FAIL nest_isr5: got %h want 0020", dut.isr_r); end
        irq_in = 8'h22;
        wr(16'h0010, 16'h0022, 2'b11);
        step();
        runs++; if (bus.int_out !== 1'b1) begin fails++; $display("FAIL nest_int_out: got %b want 1", bus.int_out); end
        runs++; if (bus.ack_vector !== 4'd1) begin fails++; $display("FAIL nest_vector1: got %0d want 1", bus.ack_vector); end
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        runs++; if (dut.isr_r !== 16'h0022) begin fails++; $display("FAIL nest_isr22: got %h want 0022", dut.isr_r); end
        step();
        runs++; if (bus.int_out !== 1'b0) begin fails++; $display("FAIL nest_masked: got %b want 0", bus.int_out); end
        wr(16'h0016, 16'h0000, 2'b01);
        runs++; if (dut.isr_r !== 16'h0020) begin fails++; $display("FAIL nest_eoi: got %h want 0020", dut.isr_r); end
    endtask

    task automatic test_simultaneous();
        logic [15:0] d;
        apply_reset();
        wr(16'h0014, 16'h0001, 2'b11);
        irq_in = 8'h01;
        wr(16'h0012, 16'h0001, 2'b01);
        irq_in = 8'h00;
        rd(16'h0012, d);
        runs++; if (d !== 16'h0001) begin fails++; $display("FAIL sim_set_wins: got %h want 0001", d); end
        wr(16'h0012, 16'h0001, 2'b01);
        rd(16'h0012, d);
        runs++; if (d !== 16'h0000) begin fails++; $display("FAIL sim_w1c: got %h want 0000", d); end
        irq_in = 8'h10;
        step();
        wr(16'h0012, 16'h0010, 2'b11);
        rd(16'h0012, d);
        runs++; if (d !== 16'h0010) begin fails++; $display("FAIL sim_w1c_level: got %h want 0010", d); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        wr(16'h0010, 16'h0003, 2'b11);
        irq_in = 8'h02;
        step();
        step();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
        runs++; if (dut.isr_r !== 16'h0002) begin fails++; $display("FAIL b2b_isr1: got %h want 0002", dut.isr_r); end
        irq_in = 8'h03;
        step();
        runs++; if (bus.ack_vector !== 4'd0) begin fails++; $display("FAIL b2b_vector0: got %0d want 0", bus.ack_vector); end
        bus.ack = 1'b1;
        wr(16'h0016, 16'h0000, 2'b01);
        bus.ack = 1'b0;
        runs++; if (dut.isr_r !== 16'h0001) begin fails++; $display("FAIL b2b_eoi_ack: got %h want 0001", dut.isr_r); end
        #3;
        reset = 1'b0;
        #1;
        runs++; if (dut.isr_r !== 16'h0000) begin fails++; $display("FAIL async_rst_isr: got %h want 0000", dut.isr_r); end
        runs++; if (bus.int_out !== 1'b0) begin fails++; $display("FAIL async_rst_int: got %b want 0", bus.int_out); end
        runs++; if (dut.pending_r !== 16'h0000) begin fails++; $display("FAIL async_rst_pend: got %h want 0000", dut.pending_r); end
        irq_in = 8'h00;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_odd_write();
        logic [15:0] d;
        apply_reset();
        wr(16'h0010, 16'h00A5, 2'b11);
        wr(16'h0011, 16'hFFFF, 2'b11);
        rd(16'h0010, d);
        runs++; if (d !== 16'h00A5) begin fails++; $display("FAIL odd_write_ignored: got %h want 00a5", d); end
        wr(16'h0010, 16'hFF5A, 2'b01);
        rd(16'h0010, d);
        runs++; if (d !== 16'h005A) begin fails++; $display("FAIL byte_low: got %h want 005a", d); end
        wr(16'h0014, 16'hFFFF, 2'b10);
        rd(16'h0014, d);
        runs++; if (d !== 16'h0000) begin fails++; $display("FAIL unimpl_bits: got %h want 0000", d); end
        rd(16'h0011, d);
        runs++; if (d !== 16'h0000) begin fails++; $display("FAIL odd_read: got %h want 0000", d); end
        rd(16'h0018, d);
        runs++; if (d !== 16'h0000) begin fails++; $display("FAIL unmapped_read: got %h want 0000", d); end
        bus.dread_addr = 16'h0010;
        wr(16'h0010, 16'h0003, 2'b11);
        runs++; if (bus.dread_data !== 16'h005A) begin fails++; $display("FAIL read_old_value: got %h want 005a", bus.dread_data); end
    endtask

    task automatic test_latency();
        int n;
        int want;
`ifdef IRQCTRL_SYNC_EN
        want = 3;
`else
        want = 1;
`endif
        apply_reset();
        wr(16'h0014, 16'h0040, 2'b11);
        wr(16'h0010, 16'h0040, 2'b11);
        irq_in = 8'h40;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            n++;
            if (dut.pending_r[6] === 1'b1) break;
        end
        runs++; if (n !== want) begin fails++; $display("FAIL latency: got %0d edges want %0d", n, want); end
        irq_in = 8'h00;
    endtask

    initial begin
        runs            = 0;
        fails           = 0;
        reset           = 1'b0;
        irq_in          = 8'h00;
        bus.ack         = 1'b0;
        bus.dread_addr  = 16'h0000;
        bus.dwrite_addr = 16'h0000;
        bus.dwrite_data = 16'h0000;
        bus.dwrite_en   = 2'b00;
        test_reset();
        test_edge_priority();
        test_ack_eoi();
        test_nesting();
        test_simultaneous();
        test_back_to_back();
        test_odd_write();
        test_latency();
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end

endmodule
